branch_redirect_ctrl: RTL

- Consumer side of the EX-stage branch comparator's `br_true` flag in the pipelined CPU.
- Decides whether a resolved branch or jump is taken and computes its target.
- Issues a PC redirect to the fetch stage through a valid/ready handshake, then flushes the younger pipeline stages for a fixed drain window.
- Keeps saturating branch and taken-branch statistics counters.

---
 rtl/branch_pkg.sv | 6 +
 rtl/branch_target_calc.sv | 18 +
 rtl/branch_redirect_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// branch_pkg: shared state, comparator encodings and drain counter width
package branch_pkg;
  typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_e;
  typedef enum logic [2:0] {BR_NONE, BR_BEQ, BR_BNE, BR_BLT, BR_BGE} br_ctrl_e;
  localparam int DRAIN_W = 4;
endpackage

// File: rtl/branch_target_calc.sv
// branch_target_calc: branch/jump target adder with JALR bit0 mask and misalign detect
module branch_target_calc #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1,
  input  logic            i_is_jalr,
  output logic [XLEN-1:0] o_target,
  output logic            o_misalign
);
  logic [XLEN-1:0] w_sum;
  always_comb begin
    w_sum      = (i_is_jalr ? i_rs1 : i_pc) + i_imm;
    o_target   = i_is_jalr ? {w_sum[XLEN-1:1], 1'b0} : w_sum;
    o_misalign = o_target[1];
  end
endmodule

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: resolves EX branches/jumps, issues the fetch redirect,
// flushes younger stages for a drain window and keeps branch statistics
module branch_redirect_ctrl
  import branch_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int DRAIN_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [2:0]       ex_br_ctrl,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic             br_true,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic             redirect_ready,
  input  logic             cnt_clr,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             busy,
  output logic             misalign_err,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);
  state_e             r_state, w_next;
  logic [DRAIN_W-1:0] r_drain;
  logic [XLEN-1:0]    r_pc, w_target;
  logic [CNT_W-1:0]   r_br, r_tk;
  logic               r_mis, w_mis, w_cond, w_resolve, w_taken, w_go, w_hs;

  branch_target_calc #(.XLEN(XLEN)) u_calc (
    .i_pc       (ex_pc),
    .i_imm      (ex_imm),
    .i_rs1      (ex_rs1),
    .i_is_jalr  (ex_is_jalr),
    .o_target   (w_target),
    .o_misalign (w_mis)
  );

  // jumps outrank the comparator, so a jump with a stray br_ctrl is not counted
  always_comb begin
    w_cond    = !ex_is_jal && !ex_is_jalr && ex_br_ctrl != 3'(BR_NONE) && ex_br_ctrl <= 3'(BR_BGE);
    w_resolve = r_state == IDLE && ex_valid;
    w_taken   = ex_is_jal || ex_is_jalr || (w_cond && br_true);
    w_go      = w_resolve && w_taken && !w_mis;
    w_hs      = r_state == REDIRECT && redirect_ready;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     w_next = w_go ? REDIRECT : IDLE;
      REDIRECT: w_next = !redirect_ready ? REDIRECT : (DRAIN_CYCLES == 0 ? IDLE : DRAIN);
      DRAIN:    w_next = r_drain == DRAIN_W'(1) ? IDLE : DRAIN;
      default:  w_next = IDLE;
    endcase
  end

  always_comb begin
    redirect_valid = r_state == REDIRECT;
    flush_id_ex    = r_state == REDIRECT;
    flush_if_id    = r_state != IDLE;
    busy           = r_state != IDLE;
    redirect_pc    = r_pc;
    misalign_err   = r_mis;
    br_cnt         = r_br;
    taken_cnt      = r_tk;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pc    <= '0;
      r_mis   <= 1'b0;
      r_drain <= '0;
    end else begin
      r_pc    <= w_go ? w_target : r_pc;
      r_mis   <= w_resolve && w_taken && w_mis;
      r_drain <= w_hs ? DRAIN_W'(DRAIN_CYCLES) : (r_state == DRAIN ? r_drain - DRAIN_W'(1) : r_drain);
    end

  // saturating statistics; clear beats a same-cycle increment
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_br <= '0;
      r_tk <= '0;
    end else begin
      r_br <= cnt_clr ? '0 : (w_resolve && w_cond && r_br != '1) ? r_br + CNT_W'(1) : r_br;
      r_tk <= cnt_clr ? '0 : (w_resolve && w_cond && br_true && r_tk != '1) ? r_tk + CNT_W'(1) : r_tk;
    end
endmodule
